data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_if.sv | 21 ++
 rtl/data_memory.sv | 101 ++++++++++
 tb/tb_data_memory.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// Processor-side data memory bus: request strobes, address/data, and the
// one-cycle completion response.
interface data_memory_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;
    logic        MemReady;
    logic        MemErr;

    modport master (
        output MemRead, MemWrite, dAddress, dWriteData,
        input  dReadData, MemReady, MemErr
    );

    modport slave (
        input  MemRead, MemWrite, dAddress, dWriteData,
        output dReadData, MemReady, MemErr
    );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory with a fixed IDLE -> ACCESS -> RESP responder;
// every accepted request completes with exactly one MemReady pulse.
module data_memory #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic clk,
    input  logic rst,
    data_memory_if.slave bus
);
    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rd_q;
    logic        wr_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] offset_c;
    logic [31:0] index_c;
    logic        in_range_c;
    logic        err_c;
    logic        wr_en_c;
    logic [AW-1:0] word_c;

    // Decode the captured request; the subtraction wraps for addresses below base,
    // so the explicit >= check is what rejects them.
    always_comb begin
        offset_c   = addr_q - BASE_ADDR;
        index_c    = offset_c >> 2;
        in_range_c = (addr_q >= BASE_ADDR) && (index_c < 32'(DEPTH_WORDS));
        err_c      = (addr_q[1:0] != 2'b00) || !in_range_c || (rd_q && wr_q);
        wr_en_c    = (state == ACCESS) && wr_q && !err_c && !rst;
        word_c     = index_c[AW-1:0];
    end

    // Storage is deliberately not reset; a reset during ACCESS suppresses the write.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[word_c] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            bus.dReadData <= '0;
            bus.MemReady  <= 1'b0;
            bus.MemErr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MemRead || bus.MemWrite) begin
                        state   <= ACCESS;
                        addr_q  <= bus.dAddress;
                        wdata_q <= bus.dWriteData;
                        rd_q    <= bus.MemRead;
                        wr_q    <= bus.MemWrite;
                    end
                end
                ACCESS: begin
                    state        <= RESP;
                    bus.MemReady <= 1'b1;
                    bus.MemErr   <= err_c;
                    if (err_c) begin
                        bus.dReadData <= ERR_DATA;
                    end else if (rd_q) begin
                        bus.dReadData <= mem[word_c];
                    end else begin
                        bus.dReadData <= '0;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.MemReady  <= 1'b0;
                    bus.MemErr    <= 1'b0;
                    bus.dReadData <= '0;
                end
                default: begin
                    state         <= IDLE;
                    bus.MemReady  <= 1'b0;
                    bus.MemErr    <= 1'b0;
                    bus.dReadData <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a vector table of single transactions plus
// hand-written reset, same-edge-reset and held-request sequences.
module tb_data_memory;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    data_memory_if bus ();

    data_memory #(
        .BASE_ADDR  (32'h10010000),
        .DEPTH_WORDS(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request in cycle 0; expect silence in ACCESS, the response at +2, idle at +3.
    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_data);
        bus.MemRead    = rd;
        bus.MemWrite   = wr;
        bus.dAddress   = addr;
        bus.dWriteData = wdata;
        tick();
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        check({name, " ready_in_access"}, 32'(bus.MemReady), 32'd0);
        tick();
        check({name, " ready"}, 32'(bus.MemReady), 32'd1);
        check({name, " err"},   32'(bus.MemErr),   32'(exp_err));
        check({name, " data"},  bus.dReadData,     exp_data);
        tick();
        check({name, " ready_after"}, 32'(bus.MemReady), 32'd0);
        check({name, " data_after"},  bus.dReadData,     32'd0);
    endtask

    initial begin
        int pulses;
        n_vec  = 0;
        n_fail = 0;

        vecs[0]  = '{1'b0, 1'b1, 32'h10010004, 32'hCAFEF00D, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 32'h10010004, 32'h00000000, 1'b0, 32'hCAFEF00D};
        vecs[2]  = '{1'b1, 1'b0, 32'h10010002, 32'h00000000, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h10010000, 32'hA5A5A5A5, 1'b0, 32'h00000000};
        vecs[4]  = '{1'b0, 1'b1, 32'h10011000, 32'h11111111, 1'b1, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b0, 32'h10010000, 32'h00000000, 1'b0, 32'hA5A5A5A5};
        vecs[6]  = '{1'b0, 1'b1, 32'h10010008, 32'h0BADC0DE, 1'b0, 32'h00000000};
        vecs[7]  = '{1'b1, 1'b1, 32'h10010008, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 1'b0, 32'h10010008, 32'h00000000, 1'b0, 32'h0BADC0DE};
        vecs[9]  = '{1'b1, 1'b0, 32'h1000FFFC, 32'h00000000, 1'b1, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 1'b1, 32'h10010FFC, 32'h77777777, 1'b0, 32'h00000000};
        vecs[11] = '{1'b1, 1'b0, 32'h10010FFC, 32'h00000000, 1'b0, 32'h77777777};
        vecs[12] = '{1'b0, 1'b1, 32'h1001000C, 32'h00000000, 1'b0, 32'h00000000};
        vecs[13] = '{1'b1, 1'b0, 32'h10010000, 32'h00000000, 1'b0, 32'hA5A5A5A5};

        rst            = 1'b1;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.dAddress   = '0;
        bus.dWriteData = '0;
        tick();
        tick();
        check("reset ready", 32'(bus.MemReady), 32'd0);
        check("reset err",   32'(bus.MemErr),   32'd0);
        check("reset data",  bus.dReadData,     32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_data);
        end

        // Reset during ACCESS aborts the pending write to word 3.
        bus.MemWrite   = 1'b1;
        bus.dAddress   = 32'h1001000C;
        bus.dWriteData = 32'h12345678;
        tick();
        bus.MemWrite = 1'b0;
        rst          = 1'b1;
        pulses       = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) rst = 1'b0;
            if (bus.MemReady) pulses++;
        end
        check("abort no_ready", 32'(pulses), 32'd0);
        run_txn("abort readback", 1'b1, 1'b0, 32'h1001000C, 32'h0, 1'b0, 32'h00000000);

        // A request coinciding with reset is dropped.
        rst          = 1'b1;
        bus.MemRead  = 1'b1;
        bus.dAddress = 32'h10010004;
        tick();
        rst         = 1'b0;
        bus.MemRead = 1'b0;
        pulses      = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.MemReady) pulses++;
            tick();
        end
        check("rst_edge no_ready", 32'(pulses), 32'd0);

        // Held read for 6 cycles: pulses only at +2 and +5.
        bus.MemRead  = 1'b1;
        bus.dAddress = 32'h10010004;
        pulses       = 0;
        for (int k = 0; k < 9; k++) begin
            if (k == 6) bus.MemRead = 1'b0;
            check($sformatf("held ready c%0d", k), 32'(bus.MemReady),
                  32'((k == 2) || (k == 5)));
            if (bus.MemReady) begin
                pulses++;
                check($sformatf("held data c%0d", k), bus.dReadData, 32'hCAFEF00D);
            end
            tick();
        end
        check("held pulse_count", 32'(pulses), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
